// File: rtl/tile_dispatcher_if.sv
// PIM-side load bus of the tile dispatcher: per-unit row handshake, the
// offered A/B tile rows and the per-unit compute-start pulses.
interface tile_dispatcher_if #(
  parameter int ELEM_WIDTH      = 32,
  parameter int PIM_MATRIX_SIZE = 8,
  parameter int MAX_PIM_UNITS   = 4
);
  logic [MAX_PIM_UNITS-1:0] pim_load_valid;
  logic [MAX_PIM_UNITS-1:0] pim_load_ready;
  logic [2:0]               pim_row_idx;
  logic [ELEM_WIDTH-1:0]    pim_a_row [PIM_MATRIX_SIZE];
  logic [ELEM_WIDTH-1:0]    pim_b_row [PIM_MATRIX_SIZE];
  logic [MAX_PIM_UNITS-1:0] pim_start;

  modport master (
    output pim_load_valid, pim_row_idx, pim_a_row, pim_b_row, pim_start,
    input  pim_load_ready
  );

  modport slave (
    input  pim_load_valid, pim_row_idx, pim_a_row, pim_b_row, pim_start,
    output pim_load_ready
  );
endinterface

// File: rtl/tile_dispatcher.sv
// Streams 8x8 tiles of two snapshotted operand matrices row by row into up to
// MAX_PIM_UNITS PIM units, then pulses each unit's compute start.
module tile_dispatcher #(
  parameter int ELEM_WIDTH      = 32,
  parameter int PIM_MATRIX_SIZE = 8,
  parameter int MAX_PIM_UNITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [15:0]           matrix_size,
  input  logic [3:0]            pim_units_used,
  input  logic [ELEM_WIDTH-1:0] matrix_a [2*PIM_MATRIX_SIZE][2*PIM_MATRIX_SIZE],
  input  logic [ELEM_WIDTH-1:0] matrix_b [2*PIM_MATRIX_SIZE][2*PIM_MATRIX_SIZE],
  tile_dispatcher_if.master     pim,
  output logic                  busy,
  output logic                  dispatch_done
);
  localparam int DIM = 2 * PIM_MATRIX_SIZE;
  localparam int IW  = $clog2(DIM);
  localparam int SW  = IW + 1;
  localparam int RW  = $clog2(PIM_MATRIX_SIZE);
  localparam int UW  = (MAX_PIM_UNITS > 1) ? $clog2(MAX_PIM_UNITS) : 1;
  localparam int NW  = $clog2(MAX_PIM_UNITS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, KICK, DONE} state_t;

  state_t                state;
  state_t                next_state;
  logic [RW-1:0]         row_q;
  logic [UW-1:0]         unit_q;
  logic [NW-1:0]         units_q;
  logic [SW-1:0]         size_q;
  logic [ELEM_WIDTH-1:0] snap_a [DIM][DIM];
  logic [ELEM_WIDTH-1:0] snap_b [DIM][DIM];

  logic [NW-1:0] units_in;
  logic [SW-1:0] size_in;
  logic          xfer;
  logic          last_row;
  logic          more_units;
  logic          load_active;

  assign units_in   = (pim_units_used > 4'(MAX_PIM_UNITS)) ? NW'(MAX_PIM_UNITS) : NW'(pim_units_used);
  assign size_in    = (matrix_size > 16'(DIM)) ? SW'(DIM) : SW'(matrix_size);
  assign xfer       = (state == LOAD) && pim.pim_load_ready[unit_q];
  assign last_row   = (row_q == RW'(PIM_MATRIX_SIZE - 1));
  assign more_units = (NW'(unit_q) + NW'(1)) < units_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (units_in == '0) ? DONE : LOAD;
      LOAD:    if (xfer && last_row) next_state = KICK;
      KICK:    next_state = more_units ? LOAD : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      unit_q <= '0;
      row_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          unit_q <= '0;
          row_q  <= '0;
        end
        LOAD: if (xfer) row_q <= last_row ? '0 : row_q + RW'(1);
        KICK: begin
          unit_q <= unit_q + UW'(1);
          row_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  // Operands are captured once so the caller may reuse its buffers mid-dispatch.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && start) begin
      snap_a  <= matrix_a;
      snap_b  <= matrix_b;
      units_q <= units_in;
      size_q  <= size_in;
    end
  end

  always_comb begin
    pim.pim_load_valid = '0;
    pim.pim_start      = '0;
    pim.pim_row_idx    = '0;
    busy               = 1'b0;
    dispatch_done      = 1'b0;
    load_active        = 1'b0;
    if (!rst) begin
      case (state)
        LOAD: begin
          pim.pim_load_valid[unit_q] = 1'b1;
          pim.pim_row_idx            = 3'(row_q);
          load_active                = 1'b1;
          busy                       = 1'b1;
        end
        KICK: begin
          pim.pim_start[unit_q] = 1'b1;
          busy                  = 1'b1;
        end
        DONE: begin
          dispatch_done = 1'b1;
          busy          = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Units form a 2x2 tile grid: bit 1 picks the A row band, bit 0 the B column band.
  logic [SW-1:0] a_row_i;
  logic [SW-1:0] b_row_i;
  logic [SW-1:0] b_col_off;
  logic          a_row_ok;
  logic          b_row_ok;

  assign a_row_i   = SW'(unit_q >> 1) * SW'(PIM_MATRIX_SIZE) + SW'(row_q);
  assign b_row_i   = SW'(row_q);
  assign b_col_off = unit_q[0] ? SW'(PIM_MATRIX_SIZE) : '0;
  assign a_row_ok  = a_row_i < size_q;
  assign b_row_ok  = b_row_i < size_q;

  for (genvar j = 0; j < PIM_MATRIX_SIZE; j++) begin : g_elem
    localparam logic [SW-1:0] A_COL = SW'(j);
    logic [SW-1:0] b_col;
    assign b_col = b_col_off + SW'(j);
    assign pim.pim_a_row[j] = (load_active && a_row_ok && A_COL < size_q)
                              ? snap_a[a_row_i[IW-1:0]][j] : '0;
    assign pim.pim_b_row[j] = (load_active && b_row_ok && b_col < size_q)
                              ? snap_b[b_row_i[IW-1:0]][b_col[IW-1:0]] : '0;
  end
endmodule
